// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared constants and sizing helpers for the synchronous FIFO
//
// Contents:
//   FIFO_DATA_WIDTH, FIFO_DEPTH : default configuration (2 entries of 2 bits)
//   PTR_W, CNT_W                : pointer and occupancy widths for the default depth
//   ptr_width(), cnt_width()    : the same sizing rule for any depth
package sync_fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 2;
    localparam int FIFO_DEPTH      = 2;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Pointers index DEPTH entries and wrap naturally because DEPTH is a power of two.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - register-array storage with one write port and an asynchronous read port
//
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, clears every word to 0
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data, mem[raddr]
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int AW         = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Words are cleared only by reset; the FIFO never scrubs popped slots, so a
    // stale word stays visible on rdata until it is overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO
//
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   din   : write data, captured when a push is accepted
//   push  : write request, ignored while full
//   pop   : read request, ignored while empty
//   dout  : head entry mem[rd_ptr], combinational (stale when empty)
//   empty : occupancy == 0
//   full  : occupancy == DEPTH
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  push,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    // Flags come only from the registered count, so push/pop never reach them
    // combinationally. This is what makes push-while-full and pop-while-empty
    // resolve against the state before the edge.
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Accepted push and pop together leave occupancy unchanged.
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (dout)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - scoreboard bench for sync_fifo (directed plan plus random traffic)
module tb_sync_fifo;

    localparam int DW  = 2;
    localparam int DEP = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] din = '0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [DW-1:0] dout;
    logic          empty;
    logic          full;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: expected contents in order, and occupancy before the next edge.
    logic [DW-1:0] sb_q [$];
    int            mcount = 0;

    sync_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .push  (push),
        .pop   (pop),
        .dout  (dout),
        .empty (empty),
        .full  (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: at every falling edge compare flags with the reference occupancy,
    // compare the visible head against the scoreboard, and retire the head when
    // the consumer is popping a non-empty FIFO.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("mon_empty", int'(empty), int'(mcount == 0));
                check("mon_full", int'(full), int'(mcount == DEP));
                if (!empty) begin
                    if (sb_q.size() == 0) begin
                        check("mon_sb_underrun", 1, 0);
                    end else begin
                        check("mon_head", int'(dout), int'(sb_q[0]));
                        if (pop) void'(sb_q.pop_front());
                    end
                end
            end
        end
    end

    // Called at posedge+1; drives one cycle of stimulus, records what the
    // reference accepts, and returns at posedge+1 after the edge with idle inputs.
    task automatic step(input logic p, input logic [DW-1:0] d, input logic q);
        int nxt;
        bit acc_push;
        bit acc_pop;
        push = p;
        din  = d;
        pop  = q;
        acc_push = p && (mcount < DEP);
        acc_pop  = q && (mcount > 0);
        if (acc_push) sb_q.push_back(d);
        nxt = mcount + int'(acc_push) - int'(acc_pop);
        @(posedge clk);
        #1;
        mcount = nxt;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        push = 1'b0;
        pop = 1'b0;
        sb_q.delete();
        mcount = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic expect_out(input string name, input int e_empty, input int e_full, input int e_dout);
        check({name, "_empty"}, int'(empty), e_empty);
        check({name, "_full"}, int'(full), e_full);
        check({name, "_dout"}, int'(dout), e_dout);
    endtask

    initial begin
        #1;
        do_reset();
        expect_out("reset", 1, 0, 0);

        step(1, 2'd1, 0);  expect_out("push1", 0, 0, 1);
        step(1, 2'd2, 0);  expect_out("push2", 0, 1, 1);
        step(1, 2'd3, 0);  expect_out("overflow", 0, 1, 1);
        step(0, 2'd0, 1);  expect_out("pop1", 0, 0, 2);
        step(0, 2'd0, 1);  expect_out("pop2_stale", 1, 0, 1);
        step(0, 2'd0, 1);  expect_out("underflow", 1, 0, 1);
        step(1, 2'd3, 0);  expect_out("push_after_uf", 0, 0, 3);

        do_reset();
        step(1, 2'd1, 0);  expect_out("one_entry", 0, 0, 1);
        step(1, 2'd2, 1);  expect_out("pushpop_mid", 0, 0, 2);
        step(1, 2'd3, 0);  expect_out("refill", 0, 1, 2);
        step(1, 2'd1, 1);  expect_out("pushpop_full", 0, 0, 3);
        step(1, 2'd2, 0);  expect_out("full_again", 0, 1, 3);

        // Reset between edges must clear outputs without waiting for a clock.
        #2;
        rst = 1'b1;
        sb_q.delete();
        mcount = 0;
        #1;
        expect_out("async_reset", 1, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
                expect_out("rand_reset", 1, 0, 0);
            end else begin
                step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
            end
        end

        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
